// File: rtl/ctrl_pkg.sv
// Shared encodings, control-word layout and bubble constant for the ID-stage control unit.
package ctrl_pkg;

  localparam int unsigned CTRL_ALUOP_W = 6;

  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_REGIMM   = 6'b000001;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] OP_JAL      = 6'b000011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BNE      = 6'b000101;
  localparam logic [5:0] OP_BLEZ     = 6'b000110;
  localparam logic [5:0] OP_BGTZ     = 6'b000111;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
  localparam logic [5:0] OP_SLTI     = 6'b001010;
  localparam logic [5:0] OP_ANDI     = 6'b001100;
  localparam logic [5:0] OP_ORI      = 6'b001101;
  localparam logic [5:0] OP_XORI     = 6'b001110;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_LB       = 6'b100000;
  localparam logic [5:0] OP_LH       = 6'b100001;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_SB       = 6'b101000;
  localparam logic [5:0] OP_SH       = 6'b101001;
  localparam logic [5:0] OP_SW       = 6'b101011;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_MUL = 6'b000010;

  typedef enum logic [1:0] {
    REGDST_RT   = 2'b00,
    REGDST_RD   = 2'b01,
    REGDST_LINK = 2'b10
  } regdst_e;

  typedef enum logic [1:0] {
    MEM_WORD = 2'b00,
    MEM_HALF = 2'b01,
    MEM_BYTE = 2'b10
  } memsize_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_WAIT = 1'b1
  } mul_state_e;

  typedef struct packed {
    regdst_e                 regdst;
    logic [CTRL_ALUOP_W-1:0] aluop;
    logic                    alusrc;
    logic                    branch;
    logic                    jump;
    logic                    link;
    logic                    memread;
    logic                    memwrite;
    memsize_e                memsize;
    logic                    memtoreg;
    logic                    regwrite;
    logic                    valid;
    logic                    illegal;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_BUBBLE = '0;

  // Access width of a load/store opcode.
  function automatic memsize_e mem_size(input logic [5:0] op);
    case (op)
      OP_LH, OP_SH: mem_size = MEM_HALF;
      OP_LB, OP_SB: mem_size = MEM_BYTE;
      default:      mem_size = MEM_WORD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational MIPS instruction decoder producing the ID-stage control word
// and the side flags needed by the hazard and mul-stall logic.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] Instruction,
  output ctrl_word_t  ctrl,
  output logic        reads_rt,
  output logic        is_mul,
  output logic        illegal
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_fields;

  assign op            = Instruction[31:26];
  assign funct         = Instruction[5:0];
  assign unused_fields = ^Instruction[25:6];

  always_comb begin
    ctrl       = CTRL_BUBBLE;
    reads_rt   = 1'b0;
    is_mul     = 1'b0;
    illegal    = 1'b0;
    ctrl.valid = 1'b1;
    ctrl.aluop = op;

    case (op)
      OP_RTYPE: begin
        ctrl.aluop    = '0;
        ctrl.regdst   = REGDST_RD;
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        reads_rt      = 1'b1;
        if (funct == FN_JR) begin
          ctrl.jump     = 1'b1;
          ctrl.regwrite = 1'b0;
        end
      end
      OP_SPECIAL2: begin
        if (funct == FN_MUL) begin
          ctrl.regdst   = REGDST_RD;
          ctrl.memtoreg = 1'b1;
          ctrl.regwrite = 1'b1;
          reads_rt      = 1'b1;
          is_mul        = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OP_LW, OP_LH, OP_LB: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.memsize  = mem_size(op);
      end
      OP_SW, OP_SH, OP_SB: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memwrite = 1'b1;
        ctrl.memsize  = mem_size(op);
        reads_rt      = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.branch = 1'b1;
        reads_rt    = 1'b1;
      end
      OP_BGTZ, OP_BLEZ, OP_REGIMM: begin
        ctrl.branch = 1'b1;
      end
      OP_J: begin
        ctrl.jump = 1'b1;
      end
      OP_JAL: begin
        ctrl.jump     = 1'b1;
        ctrl.link     = 1'b1;
        ctrl.regdst   = REGDST_LINK;
        ctrl.regwrite = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase

    // Undecoded opcodes travel down the pipe as a flagged bubble.
    if (illegal) begin
      ctrl         = CTRL_BUBBLE;
      ctrl.illegal = 1'b1;
      reads_rt     = 1'b0;
      is_mul       = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID-stage control unit: decodes IF/ID, registers the ID/EX control word,
// and owns load-use detection, mul stall sequencing and branch squash.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W  = 6,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned LINK_REG = 31,
  parameter int unsigned MUL_LAT  = 4
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [31:0]        Instruction,
  input  logic               InstrValid,
  input  logic               BranchTaken,
  output logic               Stall,
  output logic [1:0]         RegDst,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               ALUSrc,
  output logic               Branch,
  output logic               Jump,
  output logic               Link,
  output logic               MemRead,
  output logic               MemWrite,
  output logic [1:0]         MemSize,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               CtrlValid,
  output logic               IllegalOp
);

  localparam int unsigned     CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

  ctrl_word_t       dec_ctrl;
  logic             dec_reads_rt;
  logic             dec_is_mul;
  logic             dec_illegal;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic [REG_W-1:0] rd;
  logic [REG_W-1:0] dec_dest;
  logic             load_use;

  ctrl_word_t       ctrl_q;
  logic [REG_W-1:0] ex_dest_q;
  mul_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;

  ctrl_decode u_decode (
    .Instruction (Instruction),
    .ctrl        (dec_ctrl),
    .reads_rt    (dec_reads_rt),
    .is_mul      (dec_is_mul),
    .illegal     (dec_illegal)
  );

  assign rs = REG_W'(Instruction[25:21]);
  assign rt = REG_W'(Instruction[20:16]);
  assign rd = REG_W'(Instruction[15:11]);

  // Destination the instruction will write once it reaches EX.
  always_comb begin
    dec_dest = rt;
    case (dec_ctrl.regdst)
      REGDST_RD:   dec_dest = rd;
      REGDST_LINK: dec_dest = REG_W'(LINK_REG);
      default:     dec_dest = rt;
    endcase
  end

  assign load_use = InstrValid && ctrl_q.memread && (ex_dest_q != '0) &&
                    ((ex_dest_q == rs) || (dec_reads_rt && (ex_dest_q == rt)));

  assign Stall = !BranchTaken && ((state_q == ST_MUL_WAIT) || load_use);

  // ID/EX control register plus mul wait sequencer.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ctrl_q    <= CTRL_BUBBLE;
      ex_dest_q <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
    end else if (BranchTaken) begin
      ctrl_q    <= CTRL_BUBBLE;
      ex_dest_q <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (InstrValid && !load_use) begin
            ctrl_q    <= dec_ctrl;
            ex_dest_q <= dec_illegal ? '0 : dec_dest;
            if (dec_is_mul && (MUL_LAT > 1)) begin
              state_q <= ST_MUL_WAIT;
              cnt_q   <= CNT_LOAD;
            end
          end else begin
            ctrl_q    <= CTRL_BUBBLE;
            ex_dest_q <= '0;
          end
        end
        ST_MUL_WAIT: begin
          ctrl_q    <= CTRL_BUBBLE;
          ex_dest_q <= '0;
          cnt_q     <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign RegDst    = ctrl_q.regdst;
  assign ALUOp     = ALUOP_W'(ctrl_q.aluop);
  assign ALUSrc    = ctrl_q.alusrc;
  assign Branch    = ctrl_q.branch;
  assign Jump      = ctrl_q.jump;
  assign Link      = ctrl_q.link;
  assign MemRead   = ctrl_q.memread;
  assign MemWrite  = ctrl_q.memwrite;
  assign MemSize   = ctrl_q.memsize;
  assign MemtoReg  = ctrl_q.memtoreg;
  assign RegWrite  = ctrl_q.regwrite;
  assign CtrlValid = ctrl_q.valid;
  assign IllegalOp = ctrl_q.illegal;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: each step queues the expected ID/EX word
// and checks Stall before the edge and the registered word after it.
module tb_pipe_ctrl_unit;

  typedef struct packed {
    logic [1:0] regdst;
    logic [5:0] aluop;
    logic       alusrc;
    logic       branch;
    logic       jump;
    logic       link;
    logic       memread;
    logic       memwrite;
    logic [1:0] memsize;
    logic       memtoreg;
    logic       regwrite;
    logic       valid;
    logic       illegal;
  } obs_t;

  typedef struct packed {
    logic [31:0] ins;
    logic        vld;
    logic        br;
    logic        rst;
    logic        stall;
    obs_t        word;
  } step_t;

  localparam obs_t W_BUB  = '0;
  localparam obs_t W_ADD  = '{regdst: 2'b01, memtoreg: 1'b1, regwrite: 1'b1, valid: 1'b1, default: '0};
  localparam obs_t W_LW   = '{aluop: 6'h23, alusrc: 1'b1, memread: 1'b1, regwrite: 1'b1, valid: 1'b1, default: '0};
  localparam obs_t W_LH   = '{aluop: 6'h21, alusrc: 1'b1, memread: 1'b1, memsize: 2'b01, regwrite: 1'b1, valid: 1'b1, default: '0};
  localparam obs_t W_ADDI = '{aluop: 6'h08, alusrc: 1'b1, memtoreg: 1'b1, regwrite: 1'b1, valid: 1'b1, default: '0};
  localparam obs_t W_SW   = '{aluop: 6'h2b, alusrc: 1'b1, memwrite: 1'b1, valid: 1'b1, default: '0};
  localparam obs_t W_SB   = '{aluop: 6'h28, alusrc: 1'b1, memwrite: 1'b1, memsize: 2'b10, valid: 1'b1, default: '0};
  localparam obs_t W_MUL  = '{regdst: 2'b01, aluop: 6'h1c, memtoreg: 1'b1, regwrite: 1'b1, valid: 1'b1, default: '0};
  localparam obs_t W_JAL  = '{regdst: 2'b10, aluop: 6'h03, jump: 1'b1, link: 1'b1, regwrite: 1'b1, valid: 1'b1, default: '0};
  localparam obs_t W_BEQ  = '{aluop: 6'h04, branch: 1'b1, valid: 1'b1, default: '0};
  localparam obs_t W_ILL  = '{illegal: 1'b1, default: '0};

  logic        Clk;
  logic        Rst;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic        BranchTaken;
  logic        Stall;
  logic [1:0]  RegDst;
  logic [5:0]  ALUOp;
  logic        ALUSrc;
  logic        Branch;
  logic        Jump;
  logic        Link;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  MemSize;
  logic        MemtoReg;
  logic        RegWrite;
  logic        CtrlValid;
  logic        IllegalOp;

  int   checks = 0;
  int   passed = 0;
  obs_t sb[$];

  pipe_ctrl_unit dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Instruction (Instruction),
    .InstrValid  (InstrValid),
    .BranchTaken (BranchTaken),
    .Stall       (Stall),
    .RegDst      (RegDst),
    .ALUOp       (ALUOp),
    .ALUSrc      (ALUSrc),
    .Branch      (Branch),
    .Jump        (Jump),
    .Link        (Link),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemSize     (MemSize),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .CtrlValid   (CtrlValid),
    .IllegalOp   (IllegalOp)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic step_t mk(input logic [31:0] ins, input logic vld, input logic br,
                               input logic rst, input logic stall, input obs_t word);
    step_t s;
    s.ins = ins; s.vld = vld; s.br = br; s.rst = rst; s.stall = stall; s.word = word;
    return s;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o = {RegDst, ALUOp, ALUSrc, Branch, Jump, Link, MemRead, MemWrite,
         MemSize, MemtoReg, RegWrite, CtrlValid, IllegalOp};
    return o;
  endfunction

  // Drives one step's inputs after the falling edge and queues its expected word.
  task automatic apply(input step_t s);
    @(negedge Clk);
    Rst         = s.rst;
    Instruction = s.ins;
    InstrValid  = s.vld;
    BranchTaken = s.br;
    sb.push_back(s.word);
    #1;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    step_t s[4];
    obs_t  exp_w, got;
    for (int i = 0; i < 3; i++) s[i] = mk(rtype(1, 2, 3, 6'h20), 1'b1, 1'b0, 1'b1, 1'b0, W_BUB);
    s[3] = mk(rtype(1, 2, 3, 6'h20), 1'b1, 1'b0, 1'b0, 1'b0, W_ADD);
    for (int i = 0; i < 4; i++) begin
      apply(s[i]);
      if (!s[i].rst) begin
        checks++;
        if (Stall !== s[i].stall) $display("FAIL reset step %0d Stall: got %b required %b", i, Stall, s[i].stall);
        else passed++;
      end
      tick();
      exp_w = sb.pop_front();
      got   = observe();
      checks++;
      if (got !== exp_w) $display("FAIL reset step %0d word: got %h required %h", i, got, exp_w);
      else passed++;
    end
  endtask

  task automatic test_load_use();
    step_t s[10];
    obs_t  exp_w, got;
    s[0] = mk(itype(6'h23, 1, 5, 0), 1'b1, 1'b0, 1'b0, 1'b0, W_LW);
    s[1] = mk(rtype(5, 2, 6, 6'h20), 1'b1, 1'b0, 1'b0, 1'b1, W_BUB);
    s[2] = mk(rtype(5, 2, 6, 6'h20), 1'b1, 1'b0, 1'b0, 1'b0, W_ADD);
    s[3] = mk(itype(6'h23, 1, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0, W_LW);
    s[4] = mk(rtype(0, 0, 7, 6'h20), 1'b1, 1'b0, 1'b0, 1'b0, W_ADD);
    s[5] = mk(itype(6'h23, 1, 5, 0), 1'b1, 1'b0, 1'b0, 1'b0, W_LW);
    s[6] = mk(itype(6'h08, 1, 5, 7), 1'b1, 1'b0, 1'b0, 1'b0, W_ADDI);
    s[7] = mk(itype(6'h21, 1, 5, 0), 1'b1, 1'b0, 1'b0, 1'b0, W_LH);
    s[8] = mk(itype(6'h2b, 2, 5, 0), 1'b1, 1'b0, 1'b0, 1'b1, W_BUB);
    s[9] = mk(itype(6'h2b, 2, 5, 0), 1'b1, 1'b0, 1'b0, 1'b0, W_SW);
    for (int i = 0; i < 10; i++) begin
      apply(s[i]);
      checks++;
      if (Stall !== s[i].stall) $display("FAIL load_use step %0d Stall: got %b required %b", i, Stall, s[i].stall);
      else passed++;
      tick();
      exp_w = sb.pop_front();
      got   = observe();
      checks++;
      if (got !== exp_w) $display("FAIL load_use step %0d word: got %h required %h", i, got, exp_w);
      else passed++;
    end
  endtask

  task automatic test_mul();
    step_t s[5];
    obs_t  exp_w, got;
    s[0] = mk({6'h1c, 5'd1, 5'd2, 5'd4, 5'd0, 6'h02}, 1'b1, 1'b0, 1'b0, 1'b0, W_MUL);
    for (int i = 1; i < 4; i++) s[i] = mk(rtype(1, 2, 3, 6'h20), 1'b1, 1'b0, 1'b0, 1'b1, W_BUB);
    s[4] = mk(rtype(1, 2, 3, 6'h20), 1'b1, 1'b0, 1'b0, 1'b0, W_ADD);
    for (int i = 0; i < 5; i++) begin
      apply(s[i]);
      checks++;
      if (Stall !== s[i].stall) $display("FAIL mul step %0d Stall: got %b required %b", i, Stall, s[i].stall);
      else passed++;
      tick();
      exp_w = sb.pop_front();
      got   = observe();
      checks++;
      if (got !== exp_w) $display("FAIL mul step %0d word: got %h required %h", i, got, exp_w);
      else passed++;
    end
  endtask

  task automatic test_jump_store();
    step_t s[3];
    obs_t  exp_w, got;
    s[0] = mk({6'h03, 26'h100}, 1'b1, 1'b0, 1'b0, 1'b0, W_JAL);
    s[1] = mk(itype(6'h28, 1, 2, 4), 1'b1, 1'b0, 1'b0, 1'b0, W_SB);
    s[2] = mk(itype(6'h04, 1, 2, 8), 1'b1, 1'b0, 1'b0, 1'b0, W_BEQ);
    for (int i = 0; i < 3; i++) begin
      apply(s[i]);
      checks++;
      if (Stall !== s[i].stall) $display("FAIL jump_store step %0d Stall: got %b required %b", i, Stall, s[i].stall);
      else passed++;
      tick();
      exp_w = sb.pop_front();
      got   = observe();
      checks++;
      if (got !== exp_w) $display("FAIL jump_store step %0d word: got %h required %h", i, got, exp_w);
      else passed++;
    end
  endtask

  task automatic test_branch_abort();
    step_t s[6];
    obs_t  exp_w, got;
    s[0] = mk({6'h1c, 5'd1, 5'd2, 5'd4, 5'd0, 6'h02}, 1'b1, 1'b0, 1'b0, 1'b0, W_MUL);
    s[1] = mk(rtype(1, 2, 3, 6'h20), 1'b1, 1'b0, 1'b0, 1'b1, W_BUB);
    s[2] = mk(rtype(1, 2, 3, 6'h20), 1'b1, 1'b1, 1'b0, 1'b0, W_BUB);
    s[3] = mk(rtype(1, 2, 3, 6'h20), 1'b1, 1'b0, 1'b0, 1'b0, W_ADD);
    s[4] = mk({6'h3f, 26'h0}, 1'b1, 1'b0, 1'b0, 1'b0, W_ILL);
    s[5] = mk(rtype(1, 2, 3, 6'h20), 1'b0, 1'b0, 1'b0, 1'b0, W_BUB);
    for (int i = 0; i < 6; i++) begin
      apply(s[i]);
      checks++;
      if (Stall !== s[i].stall) $display("FAIL branch_abort step %0d Stall: got %b required %b", i, Stall, s[i].stall);
      else passed++;
      tick();
      exp_w = sb.pop_front();
      got   = observe();
      checks++;
      if (got !== exp_w) $display("FAIL branch_abort step %0d word: got %h required %h", i, got, exp_w);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_stall();
    step_t s[3];
    obs_t  exp_w, got;
    s[0] = mk(itype(6'h23, 1, 5, 0), 1'b1, 1'b0, 1'b0, 1'b0, W_LW);
    s[1] = mk(rtype(5, 2, 6, 6'h20), 1'b1, 1'b0, 1'b1, 1'b1, W_BUB);
    s[2] = mk(rtype(5, 2, 6, 6'h20), 1'b1, 1'b0, 1'b0, 1'b0, W_ADD);
    for (int i = 0; i < 3; i++) begin
      apply(s[i]);
      if (!s[i].rst) begin
        checks++;
        if (Stall !== s[i].stall) $display("FAIL reset_mid_stall step %0d Stall: got %b required %b", i, Stall, s[i].stall);
        else passed++;
      end
      tick();
      exp_w = sb.pop_front();
      got   = observe();
      checks++;
      if (got !== exp_w) $display("FAIL reset_mid_stall step %0d word: got %h required %h", i, got, exp_w);
      else passed++;
    end
  endtask

  initial begin
    Rst         = 1'b1;
    Instruction = '0;
    InstrValid  = 1'b0;
    BranchTaken = 1'b0;
    test_reset();
    test_load_use();
    test_mul();
    test_jump_store();
    test_branch_abort();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
